// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer with valid/ready on every port, explicit or round-robin routing.
// Optional macro STREAM_DEMUX_DROP_CNT_EN adds a saturating drop_cnt output for discarded out-of-range beats.
module stream_demux_1xn #(
   parameter int N_OUT = 8,
   parameter int DW    = 8,
   parameter int SEL_W = $clog2(N_OUT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rr_mode,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DW-1:0]         s_data,
   input  logic [SEL_W-1:0]      s_sel,
   output logic [N_OUT-1:0]      m_valid,
   input  logic [N_OUT-1:0]      m_ready,
   output logic [N_OUT*DW-1:0]   m_data,
   output logic                  sel_err
`ifdef STREAM_DEMUX_DROP_CNT_EN
   ,
   output logic [15:0]           drop_cnt
`endif
);

   function automatic logic sel_in_range(input logic [SEL_W-1:0] s);
      return ({1'b0, s} < (SEL_W+1)'(N_OUT));
   endfunction

   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] p);
      return (p == SEL_W'(N_OUT - 1)) ? '0 : p + SEL_W'(1);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic                 vld_p1;
   logic [SEL_W-1:0]     dest_p1;
   logic [DW-1:0]        data_p1;
   logic [SEL_W-1:0]     rr_ptr;

   logic                 dest_ready;
   logic [SEL_W-1:0]     sel_mux;
   logic                 accept;
   logic                 drain;
   logic                 keep_beat;

   always_comb begin
      dest_ready = 1'b0;
      m_valid    = '0;
      for (int k = 0; k < N_OUT; k++) begin
         if (dest_p1 == SEL_W'(k)) begin
            dest_ready = m_ready[k];
            m_valid[k] = vld_p1;
         end
      end
   end

   assign s_ready   = ~vld_p1 | dest_ready;
   assign m_data    = {N_OUT{data_p1}};
   assign sel_mux   = rr_mode ? rr_ptr : s_sel;
   assign accept    = s_valid & s_ready;
   assign drain     = vld_p1 & dest_ready;
   // The round-robin pointer never leaves range, so only an explicit select can be discarded.
   assign keep_beat = sel_in_range(sel_mux);

   // Stage p0 -> p1: single holding register, reload on accept, clear on drain
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         dest_p1 <= '0;
         data_p1 <= '0;
         rr_ptr  <= '0;
         sel_err <= 1'b0;
      end else begin
         if (accept) begin
            if (keep_beat) begin
               vld_p1  <= 1'b1;
               dest_p1 <= sel_mux;
               data_p1 <= s_data;
            end else begin
               // Accepting implies the register was empty or draining, so it ends up empty.
               vld_p1  <= 1'b0;
               sel_err <= 1'b1;
            end
            if (rr_mode)
               rr_ptr <= rr_next(rr_ptr);
         end else if (drain) begin
            vld_p1 <= 1'b0;
         end
      end
   end

`ifdef STREAM_DEMUX_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= 16'd0;
      else if (accept && !keep_beat)
         drop_cnt <= sat_inc16(drop_cnt);
   end
`else
   logic unused_sat;
   assign unused_sat = ^sat_inc16(16'd0);
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Directed bench for stream_demux_1xn: an N_OUT=8 instance for routing/backpressure/round-robin/reset
// and an N_OUT=6 instance for out-of-range selects (drop_cnt checked when STREAM_DEMUX_DROP_CNT_EN is set).
module tb_stream_demux_1xn;

   logic        clk = 1'b0;
   logic        rst;

   logic        rr_mode8, s_valid8, s_ready8, sel_err8;
   logic [7:0]  s_data8;
   logic [2:0]  s_sel8;
   logic [7:0]  m_valid8, m_ready8;
   logic [63:0] m_data8;

   logic        rr_mode6, s_valid6, s_ready6, sel_err6;
   logic [7:0]  s_data6;
   logic [2:0]  s_sel6;
   logic [5:0]  m_valid6, m_ready6;
   logic [47:0] m_data6;
`ifdef STREAM_DEMUX_DROP_CNT_EN
   logic [15:0] drop_cnt8, drop_cnt6;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_demux_1xn #(.N_OUT(8), .DW(8)) u8 (
      .clk(clk), .rst(rst), .rr_mode(rr_mode8),
      .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8), .s_sel(s_sel8),
      .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .sel_err(sel_err8)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      , .drop_cnt(drop_cnt8)
`endif
   );

   stream_demux_1xn #(.N_OUT(6), .DW(8)) u6 (
      .clk(clk), .rst(rst), .rr_mode(rr_mode6),
      .s_valid(s_valid6), .s_ready(s_ready6), .s_data(s_data6), .s_sel(s_sel6),
      .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6), .sel_err(sel_err6)
`ifdef STREAM_DEMUX_DROP_CNT_EN
      , .drop_cnt(drop_cnt6)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      rr_mode8 = 1'b0; s_valid8 = 1'b0; s_data8 = 8'h00; s_sel8 = 3'd0; m_ready8 = 8'hFF;
      rr_mode6 = 1'b0; s_valid6 = 1'b0; s_data6 = 8'h00; s_sel6 = 3'd0; m_ready6 = 6'h3F;

      // 1. reset held for two cycles
      tick();
      tick();
      rst = 1'b0;
      chk("rst_m_valid", 64'(m_valid8), 64'h0);
      chk("rst_m_data", m_data8, 64'h0);
      chk("rst_s_ready", 64'(s_ready8), 64'h1);
      chk("rst_sel_err", 64'(sel_err8), 64'h0);

      // 2. explicit routing, back-to-back, all ready
      for (int k = 0; k < 8; k++) begin
         s_valid8 = 1'b1;
         s_sel8   = 3'(k);
         s_data8  = 8'hA0 + 8'(k);
         #1;
         chk("route_s_ready", 64'(s_ready8), 64'h1);
         tick();
         chk("route_m_valid", 64'(m_valid8), 64'(8'h01 << k));
         chk("route_lane", 64'(m_data8[k*8 +: 8]), 64'(8'hA0 + 8'(k)));
      end
      s_valid8 = 1'b0;
      tick();
      chk("route_drained", 64'(m_valid8), 64'h0);

      // 3. backpressure on channel 3
      m_ready8 = 8'hF7;
      s_valid8 = 1'b1; s_sel8 = 3'd3; s_data8 = 8'h55;
      tick();
      s_sel8 = 3'd1; s_data8 = 8'h66;
      for (int i = 0; i < 5; i++) begin
         chk("bp_s_ready", 64'(s_ready8), 64'h0);
         chk("bp_m_valid", 64'(m_valid8), 64'h08);
         chk("bp_lane3", 64'(m_data8[24 +: 8]), 64'h55);
         tick();
      end
      m_ready8 = 8'hFF;
      #1;
      chk("bp_release_s_ready", 64'(s_ready8), 64'h1);
      tick();
      chk("bp_next_m_valid", 64'(m_valid8), 64'h02);
      chk("bp_next_lane1", 64'(m_data8[8 +: 8]), 64'h66);
      s_valid8 = 1'b0;
      tick();
      chk("bp_drained", 64'(m_valid8), 64'h0);

      // 4. round-robin: 0..7,0,1 then a detour through explicit mode
      rr_mode8 = 1'b1; s_valid8 = 1'b1; s_sel8 = 3'd5;
      for (int i = 0; i < 10; i++) begin
         s_data8 = 8'h10 + 8'(i);
         tick();
         chk("rr_m_valid", 64'(m_valid8), 64'(8'h01 << (i % 8)));
         chk("rr_lane", 64'(m_data8[(i % 8)*8 +: 8]), 64'(8'h10 + 8'(i)));
      end
      rr_mode8 = 1'b0; s_sel8 = 3'd6; s_data8 = 8'h77;
      tick();
      chk("rr_off_m_valid", 64'(m_valid8), 64'h40);
      rr_mode8 = 1'b1; s_data8 = 8'h78;
      tick();
      chk("rr_resume_m_valid", 64'(m_valid8), 64'h04);
      chk("rr_resume_lane2", 64'(m_data8[16 +: 8]), 64'h78);
      s_valid8 = 1'b0;
      tick();

      // 5. out-of-range select on the 6-channel instance
      chk("oor_sel_err_pre", 64'(sel_err6), 64'h0);
      s_valid6 = 1'b1; s_sel6 = 3'd7; s_data6 = 8'h99;
      #1;
      chk("oor_s_ready", 64'(s_ready6), 64'h1);
      tick();
      chk("oor_m_valid", 64'(m_valid6), 64'h0);
      chk("oor_sel_err", 64'(sel_err6), 64'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
      chk("oor_drop_cnt1", 64'(drop_cnt6), 64'h1);
`endif
      s_sel6 = 3'd5; s_data6 = 8'h5A;
      tick();
      chk("oor_valid_beat", 64'(m_valid6), 64'h20);
      chk("oor_valid_lane5", 64'(m_data6[40 +: 8]), 64'h5A);
      s_sel6 = 3'd6; s_data6 = 8'h11;
      tick();
      chk("oor_drain_discard", 64'(m_valid6), 64'h0);
      chk("oor_sel_err_sticky", 64'(sel_err6), 64'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
      chk("oor_drop_cnt2", 64'(drop_cnt6), 64'h2);
      s_sel6 = 3'd7;
      for (int i = 0; i < 65536; i++) @(posedge clk);
      #1;
      chk("oor_drop_cnt_sat", 64'(drop_cnt6), 64'hFFFF);
`endif
      s_valid6 = 1'b0;
      tick();

      // 6. reset while a beat is held under backpressure
      m_ready8 = 8'h00; rr_mode8 = 1'b1; s_valid8 = 1'b1; s_data8 = 8'hC3;
      tick();
      chk("mid_held_m_valid", 64'(m_valid8), 64'h08);
      s_valid8 = 1'b0;
      tick();
      chk("mid_still_held", 64'(m_valid8), 64'h08);
      rst = 1'b1; s_valid8 = 1'b1; s_data8 = 8'hE1;
      tick();
      chk("mid_rst_m_valid", 64'(m_valid8), 64'h0);
      chk("mid_rst_m_data", m_data8, 64'h0);
      chk("mid_rst_sel_err6", 64'(sel_err6), 64'h0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
      chk("mid_rst_drop_cnt6", 64'(drop_cnt6), 64'h0);
`endif
      rst = 1'b0; m_ready8 = 8'hFF;
      tick();
      chk("mid_rr_ptr_zero", 64'(m_valid8), 64'h01);
      chk("mid_rr_lane0", 64'(m_data8[0 +: 8]), 64'hE1);
      s_valid8 = 1'b0;
      tick();
      chk("mid_end_drained", 64'(m_valid8), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
